// File: rtl/wb_bus_arbiter_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_bus_arbiter_pkg;

  localparam int unsigned ADR_W = 32;
  localparam int unsigned DAT_W = 32;
  localparam int unsigned SEL_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY_INST, BUSY_DATA} arb_state_e;
  typedef enum logic {INST, DATA} arb_port_e;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic [DAT_W-1:0] datwr;
  } wb_req_t;

  // Watchdog counter width; a disabled watchdog still needs a 1-bit vector.
  function automatic int unsigned wd_cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone bundle with master/slave views.
interface wishbone_if;
  import wb_bus_arbiter_pkg::*;

  logic             cyc;
  logic             stb;
  logic             we;
  logic [ADR_W-1:0] adr;
  logic [SEL_W-1:0] sel;
  logic [DAT_W-1:0] datwr;
  logic [DAT_W-1:0] datrd;
  logic             ack;

  modport master (output cyc, stb, we, adr, sel, datwr, input datrd, ack);
  modport slave  (input cyc, stb, we, adr, sel, datwr, output datrd, ack);
endinterface

// File: rtl/wb_req_buffer.sv
// Holds one single-cycle stb request until it is granted; flags requests
// that arrive while the port already has one pending or in flight.
module wb_req_buffer
  import wb_bus_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    stb,
  input  wb_req_t req_in,
  input  logic    busy,
  input  logic    grant,
  output logic    pending,
  output wb_req_t req,
  output logic    cand_c,
  output logic    overrun_c
);

  logic accept_c;

  assign accept_c  = stb && !pending && !busy;
  assign overrun_c = stb && (pending || busy);
  assign cand_c    = pending || accept_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 1'b0;
      req     <= '0;
    end else begin
      if (accept_c) req <= req_in;
      pending <= (pending || accept_c) && !grant;
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Merges the core's instruction and data Wishbone masters onto one memory
// port: one classic cycle at a time, ack routed back, hung cycles aborted.
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          FAIR           = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  wishbone_if.slave   inst_if,
  wishbone_if.slave   data_if,
  wishbone_if.master  mem_if,
  output logic        bus_timeout,
  output logic        req_overrun
);

  localparam int unsigned     WD_W     = wd_cnt_width(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit              WD_EN    = (TIMEOUT_CYCLES != 0);

  arb_state_e      state_q, state_d;
  arb_port_e       last_grant_q;
  logic [WD_W-1:0] wd_cnt_q;

  wb_req_t inst_req_in, inst_req, data_req, mem_req;
  logic    inst_pending, data_pending;
  logic    inst_cand_c, data_cand_c;
  logic    inst_ovr_c, data_ovr_c;
  logic    grant_inst, grant_data;
  logic    busy_c, done_c;
  logic [DAT_W-1:0] resp_c;

  assign inst_req_in = '{adr: inst_if.adr, sel: inst_if.sel, we: 1'b0, datwr: '0};

  wb_req_buffer u_inst_buf (
    .clk       (clk),
    .rst       (rst),
    .stb       (inst_if.stb),
    .req_in    (inst_req_in),
    .busy      (state_q == BUSY_INST),
    .grant     (grant_inst),
    .pending   (inst_pending),
    .req       (inst_req),
    .cand_c    (inst_cand_c),
    .overrun_c (inst_ovr_c)
  );

  wb_req_buffer u_data_buf (
    .clk       (clk),
    .rst       (rst),
    .stb       (data_if.stb),
    .req_in    ('{adr: data_if.adr, sel: data_if.sel, we: data_if.we, datwr: data_if.datwr}),
    .busy      (state_q == BUSY_DATA),
    .grant     (grant_data),
    .pending   (data_pending),
    .req       (data_req),
    .cand_c    (data_cand_c),
    .overrun_c (data_ovr_c)
  );

  // Memory side is a pure decode of the registered state and granted buffer.
  assign busy_c       = (state_q != IDLE);
  assign mem_req      = !busy_c ? '0 : (state_q == BUSY_DATA) ? data_req : inst_req;
  assign mem_if.cyc   = busy_c;
  assign mem_if.stb   = busy_c;
  assign mem_if.we    = mem_req.we;
  assign mem_if.adr   = mem_req.adr;
  assign mem_if.sel   = mem_req.sel;
  assign mem_if.datwr = mem_req.datwr;

  // A watchdog abort answers the core with zero data.
  assign done_c = busy_c && (mem_if.ack || bus_timeout);
  assign resp_c = mem_if.ack ? mem_if.datrd : '0;

  always_comb begin
    state_d       = state_q;
    grant_inst    = 1'b0;
    grant_data    = 1'b0;
    inst_if.ack   = 1'b0;
    inst_if.datrd = '0;
    data_if.ack   = 1'b0;
    data_if.datrd = '0;

    case (state_q)
      BUSY_INST: begin
        inst_if.ack   = done_c;
        inst_if.datrd = done_c ? resp_c : '0;
      end
      BUSY_DATA: begin
        data_if.ack   = done_c;
        data_if.datrd = done_c ? resp_c : '0;
      end
      default: ;
    endcase

    if (!busy_c || done_c) begin
      if (data_cand_c && (!inst_cand_c || !FAIR || last_grant_q == INST)) begin
        state_d    = BUSY_DATA;
        grant_data = 1'b1;
      end else if (inst_cand_c) begin
        state_d    = BUSY_INST;
        grant_inst = 1'b1;
      end else begin
        state_d    = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= INST;
      wd_cnt_q     <= '0;
      bus_timeout  <= 1'b0;
      req_overrun  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_inst) last_grant_q <= INST;
      if (grant_data) last_grant_q <= DATA;
      if (grant_inst || grant_data)       wd_cnt_q <= '0;
      else if (WD_EN && busy_c && !done_c) wd_cnt_q <= wd_cnt_q + WD_W'(1);
      // Raised for exactly the cycle in which the count reaches the limit.
      bus_timeout <= WD_EN && busy_c && !done_c && (wd_cnt_q + WD_W'(1) == WD_LIMIT);
      req_overrun <= inst_ovr_c || data_ovr_c;
    end
  end

endmodule
